// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter_pkg
//
// Shared definitions for the two-port data memory arbiter:
//   - state_t    : FSM state encoding (IDLE / ACCESS / DONE, 2 bits)
//   - PORT_CPU   : index of the CPU load/store port (port 0)
//   - PORT_AUX   : index of the secondary master port (port 1)
//   - GNT_NONE   : grant vector value when no port owns the memory
//   - port_onehot: port index -> one-hot grant vector
//   - grant_port : one-hot grant vector -> port index
// -----------------------------------------------------------------------------
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       PORT_CPU = 1'b0;
    localparam logic       PORT_AUX = 1'b1;
    localparam logic [1:0] GNT_NONE = 2'b00;

    // Convert a port index into the one-hot grant encoding used on gnt.
    function automatic logic [1:0] port_onehot(input logic port);
        logic [1:0] vec;
        vec = GNT_NONE;
        if (port == PORT_AUX) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

    // Recover the port index from a one-hot grant; only bit 1 matters because
    // the vector is guaranteed one-hot whenever the result is consumed.
    function automatic logic grant_port(input logic [1:0] gnt);
        logic port;
        port = PORT_CPU;
        if (gnt[1] == 1'b1) begin
            port = PORT_AUX;
        end else begin
            port = PORT_CPU;
        end
        return port;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Combinational two-way round-robin pick. Given the two request lines and the
// index of the port served last, produce a one-hot grant:
//   - no request      -> 00
//   - one request     -> that port
//   - both requesting -> the port that was NOT served last
//
// Ports:
//   req  in  2  request vector, bit 0 = port 0, bit 1 = port 1
//   last in  1  index of the port that completed the previous access
//   gnt  out 2  one-hot grant (00 when nothing is requested)
// -----------------------------------------------------------------------------
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick a winner; on a tie the port opposite the last-served one wins.
    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b00:   gnt = GNT_NONE;
            2'b01:   gnt = port_onehot(PORT_CPU);
            2'b10:   gnt = port_onehot(PORT_AUX);
            2'b11:   gnt = port_onehot(~last);
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares a single-port data memory between the CPU load/store path (port 0)
// and a secondary master (port 1). One transaction is in flight at a time:
//   IDLE   : wait for a request, pick a port round-robin, latch its command
//   ACCESS : present the latched command to the memory; a write commits at the
//            closing edge, a read is captured into the owner's r_data register
//   DONE   : one-cycle ack to the owner, then back to IDLE
//
// Ports:
//   clock                 in   rising-edge clock
//   reset                 in   synchronous active-high reset
//   p0_req / p1_req       in   request, held until ack
//   p0_we / p1_we         in   1 = write, 0 = read
//   p0_addr / p1_addr     in   target address
//   p0_w_data / p1_w_data in   write data
//   p0_ack / p1_ack       out  one-cycle completion pulse
//   p0_r_data / p1_r_data out  last read result of that port
//   gnt                   out  one-hot owner of the current transaction
//   mem_addr              out  memory address
//   mem_w_data            out  memory write data
//   mem_w_en              out  memory write enable
//   mem_r_data            in   combinational memory read data
// -----------------------------------------------------------------------------
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_w_data,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_r_data,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_w_data,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_r_data,

    output logic [1:0]        gnt,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              mem_w_en,
    input  logic [DATA_W-1:0] mem_r_data
);

    state_t              state_r;
    state_t              state_s;

    logic [1:0]          pick_s;
    logic                grant_s;
    logic                access_s;
    logic                finish_s;

    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_w_data_s;

    logic [1:0]          gnt_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   w_data_r;
    logic                last_r;
    logic                p0_ack_r;
    logic                p1_ack_r;
    logic [DATA_W-1:0]   p0_r_data_r;
    logic [DATA_W-1:0]   p1_r_data_r;

    rr_arb2 u_rr_arb2 (
        .req  ({p1_req, p0_req}),
        .last (last_r),
        .gnt  (pick_s)
    );

    // Next-state decode plus the per-state strobes that drive the datapath.
    always_comb begin
        state_s  = state_r;
        grant_s  = 1'b0;
        access_s = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s != GNT_NONE) begin
                    state_s = ACCESS;
                    grant_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                state_s  = DONE;
                access_s = 1'b1;
            end
            DONE: begin
                state_s  = IDLE;
                finish_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Select the command fields of the port the arbiter is about to grant.
    always_comb begin
        sel_we_s     = p0_we;
        sel_addr_s   = p0_addr;
        sel_w_data_s = p0_w_data;
        if (pick_s[1] == 1'b1) begin
            sel_we_s     = p1_we;
            sel_addr_s   = p1_addr;
            sel_w_data_s = p1_w_data;
        end else begin
            sel_we_s     = p0_we;
            sel_addr_s   = p0_addr;
            sel_w_data_s = p0_w_data;
        end
    end

    // Grant vector and latched command; gnt stays set through ACCESS and DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_r    <= GNT_NONE;
            we_r     <= 1'b0;
            addr_r   <= '0;
            w_data_r <= '0;
        end else if (grant_s) begin
            gnt_r    <= pick_s;
            we_r     <= sel_we_s;
            addr_r   <= sel_addr_s;
            w_data_r <= sel_w_data_s;
        end else if (finish_s) begin
            gnt_r    <= GNT_NONE;
        end
    end

    // Last-served pointer; resets to port 1 so port 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_r <= PORT_AUX;
        end else if (access_s) begin
            last_r <= grant_port(gnt_r);
        end
    end

    // Ack pulses: set on the edge leaving ACCESS, so they are high only in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            p0_ack_r <= 1'b0;
            p1_ack_r <= 1'b0;
        end else begin
            p0_ack_r <= access_s & gnt_r[0];
            p1_ack_r <= access_s & gnt_r[1];
        end
    end

    // Read capture into the owner's result register; writes leave it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            p0_r_data_r <= '0;
            p1_r_data_r <= '0;
        end else if (access_s && !we_r) begin
            if (gnt_r[1]) begin
                p1_r_data_r <= mem_r_data;
            end else begin
                p0_r_data_r <= mem_r_data;
            end
        end
    end

    // The write enable is decoded from the registered state (not the next
    // state), so a write whose ACCESS cycle coincides with reset still commits.
    assign mem_w_en   = (state_r == ACCESS) & we_r;
    assign mem_addr   = addr_r;
    assign mem_w_data = w_data_r;

    assign gnt        = gnt_r;
    assign p0_ack     = p0_ack_r;
    assign p1_ack     = p1_ack_r;
    assign p0_r_data  = p0_r_data_r;
    assign p1_r_data  = p1_r_data_r;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Scoreboard bench. A stimulus process issues "rounds": each port gets a list
// of back-to-back transactions. A transaction-level model computes the service
// order (round-robin on ties, one access per three cycles), the expected read
// data from a reference memory image and the expected ack cycle, and pushes
// those expectations into a queue. A separate monitor pops one entry per ack.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       p0_req = 1'b0, p1_req = 1'b0;
    logic       p0_we = 1'b0, p1_we = 1'b0;
    logic [7:0] p0_addr = 8'h00, p1_addr = 8'h00;
    logic [7:0] p0_w_data = 8'h00, p1_w_data = 8'h00;
    logic       p0_ack, p1_ack;
    logic [7:0] p0_r_data, p1_r_data;
    logic [1:0] gnt;
    logic [7:0] mem_addr, mem_w_data, mem_r_data;
    logic       mem_w_en;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_w_data(p0_w_data),
        .p0_ack(p0_ack), .p0_r_data(p0_r_data),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_w_data(p1_w_data),
        .p1_ack(p1_ack), .p1_r_data(p1_r_data),
        .gnt(gnt),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
        .mem_r_data(mem_r_data)
    );

    // Data memory attached to the arbiter: combinational read, clocked write.
    logic [7:0] mem [256];
    assign mem_r_data = mem[mem_addr];
    always @(posedge clock) begin
        if (mem_w_en) mem[mem_addr] <= mem_w_data;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    logic [7:0] ref_mem [256];
    logic       last_m;
    logic [7:0] last_rd [2];
    int         exp_writes = 0;
    int         wen_seen = 0;

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] rd;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    // Per-round transaction lists
    int         cnt [2];
    logic       t_we   [2][4];
    logic [7:0] t_addr [2][4];
    logic [7:0] t_wd   [2][4];
    logic [1:0] glog [8];
    int         glog_n;

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Predict the whole round, then drive it, advancing each port on its ack.
    task automatic run_round();
        int rem [2];
        int ix [2];
        int k;
        int c0;
        logic p;
        exp_t e;
        @(negedge clock);
        c0 = cyc;
        rem[0] = cnt[0]; rem[1] = cnt[1];
        ix[0] = 0; ix[1] = 0;
        k = 0;
        while (rem[0] > 0 || rem[1] > 0) begin
            if (rem[0] > 0 && rem[1] > 0) p = ~last_m;
            else p = (rem[0] > 0) ? 1'b0 : 1'b1;
            last_m = p;
            e.port = p;
            e.we   = t_we[p][ix[p]];
            e.addr = t_addr[p][ix[p]];
            e.wd   = t_wd[p][ix[p]];
            if (e.we) begin
                ref_mem[e.addr] = e.wd;
                exp_writes++;
            end else begin
                last_rd[p] = ref_mem[e.addr];
            end
            e.rd  = last_rd[p];
            e.cyc = c0 + 2 + 3 * k;
            sb.push_back(e);
            ix[p]++; rem[p]--; k++;
        end
        ix[0] = 0; ix[1] = 0;
        if (cnt[0] > 0) begin
            p0_req = 1'b1; p0_we = t_we[0][0]; p0_addr = t_addr[0][0]; p0_w_data = t_wd[0][0];
        end
        if (cnt[1] > 0) begin
            p1_req = 1'b1; p1_we = t_we[1][0]; p1_addr = t_addr[1][0]; p1_w_data = t_wd[1][0];
        end
        glog_n = 0;
        for (int cy = 0; cy < 3 * k + 6 && (ix[0] < cnt[0] || ix[1] < cnt[1]); cy++) begin
            @(negedge clock);
            if (glog_n < 8) begin
                glog[glog_n] = gnt;
                glog_n++;
            end
            if (p0_ack && ix[0] < cnt[0]) begin
                ix[0]++;
                if (ix[0] < cnt[0]) begin
                    p0_we = t_we[0][ix[0]]; p0_addr = t_addr[0][ix[0]]; p0_w_data = t_wd[0][ix[0]];
                end else begin
                    p0_req = 1'b0;
                end
            end
            if (p1_ack && ix[1] < cnt[1]) begin
                ix[1]++;
                if (ix[1] < cnt[1]) begin
                    p1_we = t_we[1][ix[1]]; p1_addr = t_addr[1][ix[1]]; p1_w_data = t_wd[1][ix[1]];
                end else begin
                    p1_req = 1'b0;
                end
            end
        end
        chk("round_complete", ix[0] + ix[1], cnt[0] + cnt[1]);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    // Monitor: one scoreboard entry per ack; also checks the preceding ACCESS.
    initial begin : monitor
        logic       prev_wen;
        logic [7:0] prev_addr, prev_wd;
        logic [1:0] ackv;
        exp_t       e;
        prev_wen = 1'b0; prev_addr = 8'h00; prev_wd = 8'h00;
        forever begin
            @(negedge clock);
            ackv = {p1_ack, p0_ack};
            if (ackv != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", ackv, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", ackv, onehot(e.port));
                    chk("ack_cycle", cyc, e.cyc);
                    chk("r_data", e.port ? p1_r_data : p0_r_data, e.rd);
                    chk("gnt_at_ack", gnt, onehot(e.port));
                    chk("w_en_in_access", prev_wen, e.we);
                    chk("addr_in_access", prev_addr, e.addr);
                    if (e.we) chk("w_data_in_access", prev_wd, e.wd);
                end
            end
            if (mem_w_en) wen_seen++;
            prev_wen = mem_w_en; prev_addr = mem_addr; prev_wd = mem_w_data;
        end
    end

    logic [1:0] gseq [6];
    logic [7:0] m0_save;
    int         nbad;

    initial begin : stim
        gseq[0] = 2'b01; gseq[1] = 2'b01; gseq[2] = 2'b00;
        gseq[3] = 2'b10; gseq[4] = 2'b10; gseq[5] = 2'b00;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h10] = 8'hA5; ref_mem[8'h10] = 8'hA5;
        last_m = 1'b1; last_rd[0] = 8'h00; last_rd[1] = 8'h00;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_acks", {p1_ack, p0_ack}, 2'b00);
        chk("rst_p0_r_data", p0_r_data, 8'h00);
        chk("rst_p1_r_data", p1_r_data, 8'h00);
        chk("rst_mem_w_en", mem_w_en, 1'b0);
        chk("rst_mem_addr", mem_addr, 8'h00);
        chk("rst_mem_w_data", mem_w_data, 8'h00);
        reset = 1'b0;

        // Simultaneous requests after reset: port 0 first, gnt sequence
        cnt[0] = 1; cnt[1] = 1;
        t_we[0][0] = 1'b0; t_addr[0][0] = 8'h10; t_wd[0][0] = 8'h00;
        t_we[1][0] = 1'b0; t_addr[1][0] = 8'h11; t_wd[1][0] = 8'h00;
        run_round();
        @(negedge clock);
        glog[5] = gnt;
        for (int i = 0; i < 6; i++) chk("gnt_seq", glog[i], gseq[i]);

        // Single read of the preloaded 0xA5
        cnt[0] = 1; cnt[1] = 0;
        t_we[0][0] = 1'b0; t_addr[0][0] = 8'h10;
        run_round();

        // p1 write 0x3C to 0x20, then p0 reads it back
        cnt[0] = 0; cnt[1] = 1;
        t_we[1][0] = 1'b1; t_addr[1][0] = 8'h20; t_wd[1][0] = 8'h3C;
        run_round();
        cnt[0] = 1; cnt[1] = 0;
        t_we[0][0] = 1'b0; t_addr[0][0] = 8'h20;
        run_round();

        // Sustained contention: both ports keep requesting for four accesses
        cnt[0] = 2; cnt[1] = 2;
        for (int i = 0; i < 2; i++) begin
            t_we[0][i] = 1'b0; t_addr[0][i] = 8'(8'h30 + i);
            t_we[1][i] = 1'b0; t_addr[1][i] = 8'(8'h40 + i);
        end
        run_round();

        // Address boundary: write/read 0xFF, location 0x00 untouched
        m0_save = mem[0];
        cnt[0] = 2; cnt[1] = 0;
        t_we[0][0] = 1'b1; t_addr[0][0] = 8'hFF; t_wd[0][0] = 8'hEE;
        t_we[0][1] = 1'b0; t_addr[0][1] = 8'hFF;
        run_round();
        chk("mem0_unchanged", mem[0], m0_save);

        // Reset during the ACCESS cycle of a p0 write
        @(negedge clock);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h05; p0_w_data = 8'h77;
        @(negedge clock);
        chk("racc_w_en", mem_w_en, 1'b1);
        chk("racc_addr", mem_addr, 8'h05);
        reset = 1'b1; p0_req = 1'b0;
        @(negedge clock);
        chk("racc_acks", {p1_ack, p0_ack}, 2'b00);
        chk("racc_gnt", gnt, 2'b00);
        chk("racc_mem_w_en", mem_w_en, 1'b0);
        chk("racc_mem_addr", mem_addr, 8'h00);
        chk("racc_mem_w_data", mem_w_data, 8'h00);
        chk("racc_p0_r_data", p0_r_data, 8'h00);
        chk("racc_mem05", mem[5], 8'h77);
        reset = 1'b0;
        ref_mem[5] = 8'h77; exp_writes++;
        last_m = 1'b1; last_rd[0] = 8'h00; last_rd[1] = 8'h00;

        // Next tie after reset goes to port 0
        cnt[0] = 1; cnt[1] = 1;
        t_we[0][0] = 1'b0; t_addr[0][0] = 8'h05;
        t_we[1][0] = 1'b1; t_addr[1][0] = 8'h05; t_wd[1][0] = 8'h99;
        run_round();
        chk("tie_after_reset", glog[0], 2'b01);

        // Randomized rounds
        for (int r = 0; r < 60; r++) begin
            cnt[0] = $urandom_range(0, 3);
            cnt[1] = $urandom_range(0, 3);
            if (cnt[0] + cnt[1] == 0) cnt[0] = 1;
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < 4; i++) begin
                    t_we[p][i]   = 1'($urandom_range(0, 1));
                    t_addr[p][i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
                    t_wd[p][i]   = 8'($urandom);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clock);
            run_round();
        end

        repeat (4) @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        chk("w_en_cycles", wen_seen, exp_writes);
        nbad = 0;
        for (int i = 0; i < 256; i++) begin
            if (mem[i] !== ref_mem[i]) nbad++;
        end
        chk("mem_image", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port 256×8 data memory between the CPU load/store path (port 0) and a secondary master such as a UART loader or debug port (port 1). It accepts one request at a time with a req/ack handshake and picks between ports round-robin. It drives the memory's address, write-data and write-enable inputs, and returns the captured read data to the port it granted. It sits between the masters and the data memory, and replaces the CPU's direct connection to the memory.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- p0_req, p1_req  in  1  request; held high until the matching ack
- p0_we, p1_we  in  1  1 = write, 0 = read; stable while req is high
- p0_addr, p1_addr  in  ADDR_W  target address; stable while req is high
- p0_w_data, p1_w_data  in  DATA_W  write data; stable while req is high
- p0_ack, p1_ack  out  1  one-cycle completion pulse
- p0_r_data, p1_r_data  out  DATA_W  read result; valid in the ack cycle, held until that port's next ack
- gnt  out  2  one-hot owner of the current transaction; 0 when idle
- mem_addr  out  ADDR_W  to memory addr
- mem_w_data  out  DATA_W  to memory w_data
- mem_w_en  out  1  to memory w_en
- mem_r_data  in  DATA_W  combinational read data from memory

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No req high: stay in IDLE.
  - Exactly one req high: grant that port.
  - Both req high: grant the port not served last. The pointer resets to "last = port 1", so port 0 wins the first tie.
  - On a grant: latch the port's we, addr and w_data; set gnt; go to ACCESS.
- ACCESS:
  - mem_addr = latched addr, mem_w_data = latched data.
  - mem_w_en = latched we. This is the only state in which it can be 1.
  - On a read, capture mem_r_data into the granted port's r_data register at the edge.
  - Update the last-served pointer; go to DONE.
- DONE:
  - Assert the granted port's ack for exactly one cycle; clear gnt on exit; go to IDLE.
  - On a write, r_data is unchanged.
- Requester rules:
  - A req still high in the cycle after ack is a new transaction.
  - Back-to-back requests from one port alternate with the other port whenever both are pending.
- Masters never access the memory directly; addresses wrap naturally at 2^ADDR_W.

## Timing
- Latency:
  - req sampled high at edge N (state IDLE).
  - ACCESS during cycle N+1.
  - ack and r_data valid during cycle N+2.
  - Earliest next grant at edge N+3.
  - Peak throughput: 1 access per 3 cycles.
- Write commits to memory at the edge ending the ACCESS cycle.
- Reset values: state IDLE, gnt 0, p0_ack/p1_ack 0, p0_r_data/p1_r_data 0, mem_w_en 0, mem_addr 0, mem_w_data 0, pointer "last = port 1".
- Reset in ACCESS:
  - mem_w_en is decoded from the registered state, so a pending write still commits at that edge.
  - No ack is issued; the FSM goes to IDLE.
- Reset in DONE: the ack for that cycle is still visible, and the next state is IDLE with all outputs at reset values.
- A req that drops before ack is a protocol violation; the latched transaction completes regardless.
- A req that rises while another transaction is in flight waits; it is not lost.

## Structure
- Shared package holds:
  - the state encoding constants IDLE / ACCESS / DONE (2-bit);
  - the port index constants PORT_CPU = 0 and PORT_AUX = 1.
- One natural sub-module: rr_arb2, a combinational 2-way round-robin pick from {req, last} producing a one-hot grant. It keeps the FSM free of priority logic.
- The arbiter instantiates no memory; the top level wires mem_* to the data memory.

## Test plan
- Single read: memory preloaded with [0x10]=0xA5; p0 read 0x10 -> mem_w_en stays 0, p0_ack pulses 2 cycles after req, p0_r_data=0xA5, p1_ack stays 0.
- Single write then read: p1 write 0x3C to 0x20 -> mem_w_en=1 for exactly one cycle with mem_addr=0x20; a following p0 read of 0x20 returns 0x3C.
- Simultaneous requests after reset: both req high at the same edge -> port 0 granted first, port 1 acked 3 cycles later; gnt sequence 01, 01, 00, 10, 10, 00.
- Sustained contention: both req held high for 12 cycles -> acks alternate p0, p1, p0, p1, one every 3 cycles, with no starvation.
- Reset in ACCESS during a p0 write of 0x77 to 0x05 -> memory[0x05]=0x77, no ack, outputs at reset values next cycle, next tie goes to port 0.
- Address boundary: p0 write 0xEE to 0xFF then read 0xFF -> 0xEE; memory[0x00] is unchanged.
